instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Upstream fetch stage for the single-cycle datapath. Reads the byte-wide instruction memory, assembles four consecutive bytes per instruction (big-endian: byte at PC becomes instr[31:24]), and buffers assembled words with their PC in a small prefetch FIFO. The datapath consumes words over a valid/ready handshake and redirects the fetch stream on taken branches and jumps.

## Interface
- PC_W, 8: byte-address / PC width; all address arithmetic is modulo 2^PC_W.
- FIFO_DEPTH, 4: prefetch FIFO entries; power of two, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_rd  out  1  byte read strobe.
- imem_addr  out  PC_W  byte address; meaningful only while imem_rd=1.
- imem_rdata  in  8  read data, valid in the cycle after the imem_rd cycle.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  PC_W  new PC; bits [1:0] are ignored and treated as 0.
- instr_valid  out  1  FIFO head holds a word.
- instr_ready  in  1  consumer accepts the head this cycle.
- instr  out  32  head instruction.
- instr_pc  out  PC_W  PC of the head instruction.

## Operation
- State:
  - fetch_pc (word-aligned).
  - issue counter byte_cnt 0..3.
  - rd_q: registered imem_rd, marks a returning byte.
  - receive counter rx_cnt 0..3, plus a 24-bit byte shift register.
  - pend: words issued but not yet pushed, 0..2.
  - FIFO: count, read pointer, write pointer.
- FSM has two states:
  - ISSUE: imem_rd=1, imem_addr=fetch_pc+byte_cnt.
  - HOLD: imem_rd=0.
- Word start:
  - A word starts (byte_cnt=0 issued) only when count+pend < FIFO_DEPTH, using registered values.
  - If that condition fails, the FSM goes to or stays in HOLD.
  - Bytes 1..3 of a started word always issue on the following consecutive cycles.
  - After byte 3: fetch_pc += 4, byte_cnt=0.
  - The next word may start in the very next cycle, so steady state is one word per 4 cycles.
- Receive path:
  - Each cycle with rd_q=1 captures imem_rdata and advances rx_cnt.
  - On the 4th byte, push {b0,b1,b2,imem_rdata} with the word's PC, and decrement pend.
- Pop: when instr_valid & instr_ready, advance the read pointer.
  - Push and pop in the same cycle leave count unchanged.
- Head: instr/instr_pc show the FIFO head directly. They stay stable while instr_valid & !instr_ready.
- Redirect (highest priority, sampled at the edge):
  - Clear the FIFO, pend, byte_cnt, rx_cnt and rd_q.
  - fetch_pc <= {redirect_pc[PC_W-1:2],2'b00}.
  - A push or returning byte in the redirect cycle is discarded.
  - A pop in the redirect cycle counts as consumed.
  - The next cycle is ISSUE for byte 0 at the new PC.
- Wrap: a word at 2^PC_W-4 reads the last four bytes; fetch_pc then wraps to 0.
- Reset values:
  - imem_rd=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0.
  - fetch_pc=0, FIFO empty, pend=0, FSM=ISSUE.
  - Assertion clears all state immediately, without waiting for a clock edge.

## Timing
- Cycle 0 is the first cycle with rst low (or the first cycle after a sampled redirect).
- imem_rd=1 in cycles 0-3 at addresses PC..PC+3.
- Bytes return in cycles 1-4; the push occurs at the cycle-4 edge.
- instr_valid=1 from cycle 5.
- Fill/redirect latency is 5 cycles; sustained throughput is 1 word / 4 cycles.
- With instr_ready=0 from reset: exactly 4*FIFO_DEPTH read strobes, then imem_rd stays 0.
- Popping one entry lets the next word start in the following cycle.
- instr_valid falls in the cycle after the pop of the last entry, or in the cycle after a redirect.

## Test plan
- Memory byte k = k, instr_ready=1 from reset:
  - instr_valid first in cycle 5 with instr=0x00010203, instr_pc=0.
  - Next handshake in cycle 9 with instr=0x04050607, instr_pc=4.
- instr_ready=0 from reset:
  - 16 imem_rd pulses at addresses 0..15, then idle; count=4.
  - instr holds 0x00010203.
  - Raising instr_ready drains 0x00010203 to 0x0C0D0E0F on 4 consecutive cycles; fetch resumes at address 16.
- redirect=1, redirect_pc=0x43 in the cycle after byte 1 of a word is issued:
  - Old bytes are dropped and instr_valid=0 next cycle.
  - imem_addr=0x40 next cycle.
  - First output instr=0x40414243, instr_pc=0x40, five cycles after that.
- redirect_pc=0xFC:
  - Words instr_pc=0xFC (0xFCFDFEFF), then instr_pc=0x00 (0x00010203).
- rst asserted mid-word between edges:
  - instr_valid, imem_rd and instr go to 0 immediately.
  - After release, fetch restarts at address 0 with first valid in cycle 5.
- redirect in the same cycle as a pop and a 4th-byte push:
  - The popped word is consumed and the pushed word is discarded.
  - The FIFO is empty next cycle; no stale PC ever appears at instr_pc.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit and its surroundings: the byte-wide instruction
// memory port, the redirect request and the instruction stream to the datapath.
interface instr_fetch_unit_if #(
   parameter int PC_W = 8
);
   // Handshake: a word transfers on each rising edge where instr_valid and
   // instr_ready are both 1; instr/instr_pc stay stable while valid waits on ready.
   logic            imem_rd;
   logic [PC_W-1:0] imem_addr;
   logic [7:0]      imem_rdata;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr;
   logic [PC_W-1:0] instr_pc;

   modport master (
      output imem_rd, imem_addr, instr_valid, instr, instr_pc,
      input  imem_rdata, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_rd, imem_addr, instr_valid, instr, instr_pc,
      output imem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads four bytes per instruction from byte-wide memory,
// assembles big-endian words and queues them with their PC in a prefetch FIFO.
module instr_fetch_unit #(
   parameter int PC_W       = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   instr_fetch_unit_if.master bus,
   output logic               dbg_state
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

   typedef enum logic {ISSUE = 1'b0, HOLD = 1'b1} state_t;

   state_t          state;
   state_t          state_nx;
   logic [PC_W-1:0] fetch_pc;
   logic [1:0]      byte_cnt;
   logic [1:0]      byte_cnt_nx;
   logic            rd_q;
   logic [1:0]      rx_cnt;
   logic [23:0]     rx_shift;
   logic [PC_W-1:0] rx_pc;
   logic [CW-1:0]   pend;
   logic [CW-1:0]   pend_nx;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nx;
   logic [CW:0]     occ_nx;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [31:0]     fifo_word [FIFO_DEPTH];
   logic [PC_W-1:0] fifo_pc   [FIFO_DEPTH];
   logic            issue;
   logic            start;
   logic            push;
   logic            pop;
   logic [PC_W-1:0] redir_pc;

   // Occupancy counts words already queued plus words still in flight, so a
   // started word always has a FIFO slot waiting for it.
   always_comb begin
      issue    = (state == ISSUE);
      start    = issue && (byte_cnt == 2'd0);
      push     = rd_q && (rx_cnt == 2'd3);
      pop      = (count != '0) && bus.instr_ready;
      redir_pc = bus.redirect_pc & ~(PC_W'(3));

      count_nx = count;
      if (push && !pop)
         count_nx = count + 1'b1;
      else if (pop && !push)
         count_nx = count - 1'b1;

      pend_nx = pend;
      if (start && !push)
         pend_nx = pend + 1'b1;
      else if (push && !start)
         pend_nx = pend - 1'b1;

      byte_cnt_nx = issue ? byte_cnt + 2'd1 : byte_cnt;
      occ_nx      = {1'b0, count_nx} + {1'b0, pend_nx};
      // Bytes 1..3 of a started word are never held back.
      state_nx    = ((byte_cnt_nx != 2'd0) || (occ_nx < DEPTH_W)) ? ISSUE : HOLD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ISSUE;
         fetch_pc <= '0;
         byte_cnt <= '0;
         rd_q     <= 1'b0;
         rx_cnt   <= '0;
         rx_shift <= '0;
         rx_pc    <= '0;
         pend     <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (bus.redirect) begin
         state    <= ISSUE;
         fetch_pc <= redir_pc;
         byte_cnt <= '0;
         rd_q     <= 1'b0;
         rx_cnt   <= '0;
         rx_pc    <= redir_pc;
         pend     <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         state    <= state_nx;
         byte_cnt <= byte_cnt_nx;
         rd_q     <= issue;
         pend     <= pend_nx;
         count    <= count_nx;
         if (issue && (byte_cnt == 2'd3))
            fetch_pc <= fetch_pc + PC_W'(4);
         if (rd_q) begin
            rx_cnt   <= rx_cnt + 2'd1;
            rx_shift <= {rx_shift[15:0], bus.imem_rdata};
         end
         if (push) begin
            rx_pc  <= rx_pc + PC_W'(4);
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !bus.redirect) begin
         fifo_word[wr_ptr] <= {rx_shift, bus.imem_rdata};
         fifo_pc[wr_ptr]   <= rx_pc;
      end
   end

   // Head is masked while empty so no stale word or PC is ever visible.
   always_comb begin
      bus.imem_rd     = issue && !rst;
      bus.imem_addr   = fetch_pc | {{(PC_W-2){1'b0}}, byte_cnt};
      bus.instr_valid = (count != '0);
      bus.instr       = bus.instr_valid ? fifo_word[rd_ptr] : 32'h0;
      bus.instr_pc    = bus.instr_valid ? fifo_pc[rd_ptr] : '0;
      dbg_state       = state;
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing scenarios plus a randomized run
// checked against a stream-level model of the fetched instruction sequence.
module tb_instr_fetch_unit;
   logic clk;
   logic rst;
   logic dbg_state;
   logic [7:0] mem [256];
   int total;
   int bad;

   instr_fetch_unit_if #(.PC_W(8)) bus ();

   instr_fetch_unit #(.PC_W(8), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte memory: data appears in the cycle after the strobe.
   always @(posedge clk)
      if (bus.imem_rd) bus.imem_rdata <= mem[bus.imem_addr];

   function automatic logic [31:0] word_at(input logic [7:0] pc);
      return {mem[pc], mem[pc + 8'd1], mem[pc + 8'd2], mem[pc + 8'd3]};
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Leaves the bench at the observation point of cycle 0.
   task automatic restart();
      rst = 1'b1;
      bus.instr_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.instr_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 8'h00;
      bus.imem_rdata = 8'h00;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({bus.imem_rd, bus.instr_valid} !== 2'b00) begin
         bad++; $display("FAIL reset_rd_valid got=%b exp=00", {bus.imem_rd, bus.instr_valid});
      end
      total++;
      if (bus.imem_addr !== 8'h00) begin
         bad++; $display("FAIL reset_addr got=%h exp=00", bus.imem_addr);
      end
      total++;
      if (bus.instr !== 32'h0 || bus.instr_pc !== 8'h00) begin
         bad++; $display("FAIL reset_head got=%h/%h exp=0/0", bus.instr, bus.instr_pc);
      end
   endtask

   task automatic test_fill();
      restart();
      bus.instr_ready = 1'b1;
      for (int c = 0; c <= 9; c++) begin
         total++;
         if (bus.instr_valid !== ((c == 5) || (c == 9))) begin
            bad++; $display("FAIL fill_valid cycle=%0d got=%b", c, bus.instr_valid);
         end
         total++;
         if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'(c)) begin
            bad++; $display("FAIL fill_addr cycle=%0d got rd=%b addr=%h exp addr=%h", c, bus.imem_rd, bus.imem_addr, 8'(c));
         end
         if (c == 5 || c == 9) begin
            total++;
            if (bus.instr !== ((c == 5) ? 32'h00010203 : 32'h04050607) || bus.instr_pc !== ((c == 5) ? 8'h00 : 8'h04)) begin
               bad++; $display("FAIL fill_word cycle=%0d got=%h pc=%h", c, bus.instr, bus.instr_pc);
            end
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_a;
      int rd_cnt;
      restart();
      exp_a = 8'h00;
      rd_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         if (bus.imem_rd) begin
            total++;
            if (bus.imem_addr !== exp_a) begin
               bad++; $display("FAIL bp_addr cycle=%0d got=%h exp=%h", c, bus.imem_addr, exp_a);
            end
            exp_a++;
            rd_cnt++;
         end
         step();
      end
      total++;
      if (rd_cnt !== 16) begin
         bad++; $display("FAIL bp_strobes got=%0d exp=16", rd_cnt);
      end
      total++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00010203) begin
         bad++; $display("FAIL bp_hold got v=%b %h exp 1 00010203", bus.instr_valid, bus.instr);
      end
      bus.instr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (bus.instr_valid !== 1'b1 || bus.instr !== word_at(8'(4 * k)) || bus.instr_pc !== 8'(4 * k)) begin
            bad++; $display("FAIL bp_drain k=%0d got v=%b %h pc=%h", k, bus.instr_valid, bus.instr, bus.instr_pc);
         end
         if (k == 1) begin
            total++;
            if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h10) begin
               bad++; $display("FAIL bp_resume got rd=%b addr=%h exp 1/10", bus.imem_rd, bus.imem_addr);
            end
         end
         step();
      end
      total++;
      if (bus.instr_valid !== 1'b0) begin
         bad++; $display("FAIL bp_empty got=%b exp=0", bus.instr_valid);
      end
      bus.instr_ready = 1'b0;
   endtask

   task automatic test_redirect();
      restart();
      repeat (6) step();
      total++;
      if (bus.imem_addr !== 8'h06 || bus.instr_valid !== 1'b1) begin
         bad++; $display("FAIL redir_pre got addr=%h v=%b exp 06/1", bus.imem_addr, bus.instr_valid);
      end
      bus.redirect = 1'b1;
      bus.redirect_pc = 8'h43;
      step();
      bus.redirect = 1'b0;
      for (int c = 0; c <= 5; c++) begin
         total++;
         if (bus.instr_valid !== (c == 5)) begin
            bad++; $display("FAIL redir_valid cycle=%0d got=%b", c, bus.instr_valid);
         end
         if (c < 4) begin
            total++;
            if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'(8'h40 + c)) begin
               bad++; $display("FAIL redir_addr cycle=%0d got=%h exp=%h", c, bus.imem_addr, 8'(8'h40 + c));
            end
         end
         if (c == 5) begin
            total++;
            if (bus.instr !== 32'h40414243 || bus.instr_pc !== 8'h40) begin
               bad++; $display("FAIL redir_word got=%h pc=%h exp 40414243/40", bus.instr, bus.instr_pc);
            end
         end
         step();
      end
   endtask

   task automatic test_wrap();
      restart();
      bus.instr_ready = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 8'hFC;
      step();
      bus.redirect = 1'b0;
      for (int c = 0; c <= 9; c++) begin
         total++;
         if (bus.imem_addr !== 8'(8'hFC + c)) begin
            bad++; $display("FAIL wrap_addr cycle=%0d got=%h exp=%h", c, bus.imem_addr, 8'(8'hFC + c));
         end
         if (c == 5 || c == 9) begin
            total++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== ((c == 5) ? 32'hFCFDFEFF : 32'h00010203) || bus.instr_pc !== ((c == 5) ? 8'hFC : 8'h00)) begin
               bad++; $display("FAIL wrap_word cycle=%0d got v=%b %h pc=%h", c, bus.instr_valid, bus.instr, bus.instr_pc);
            end
         end
         step();
      end
   endtask

   task automatic test_async_reset();
      restart();
      repeat (7) step();
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.instr_valid, bus.imem_rd} !== 2'b00 || bus.instr !== 32'h0 || bus.instr_pc !== 8'h00) begin
         bad++; $display("FAIL arst_clear got v=%b rd=%b %h pc=%h", bus.instr_valid, bus.imem_rd, bus.instr, bus.instr_pc);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      bus.instr_ready = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         total++;
         if (bus.instr_valid !== (c == 5) || bus.imem_addr !== 8'(c)) begin
            bad++; $display("FAIL arst_restart cycle=%0d got v=%b addr=%h", c, bus.instr_valid, bus.imem_addr);
         end
         if (c == 5) begin
            total++;
            if (bus.instr !== 32'h00010203) begin
               bad++; $display("FAIL arst_word got=%h exp=00010203", bus.instr);
            end
         end
         step();
      end
   endtask

   task automatic test_redirect_pop_push();
      restart();
      repeat (8) step();
      total++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h00010203) begin
         bad++; $display("FAIL rpp_head got v=%b %h exp 1 00010203", bus.instr_valid, bus.instr);
      end
      bus.instr_ready = 1'b1;
      bus.redirect = 1'b1;
      bus.redirect_pc = 8'h80;
      step();
      bus.redirect = 1'b0;
      for (int c = 0; c <= 5; c++) begin
         total++;
         if (bus.instr_valid !== (c == 5)) begin
            bad++; $display("FAIL rpp_valid cycle=%0d got=%b", c, bus.instr_valid);
         end
         total++;
         if (bus.instr_pc !== ((c == 5) ? 8'h80 : 8'h00)) begin
            bad++; $display("FAIL rpp_pc cycle=%0d got=%h", c, bus.instr_pc);
         end
         if (c == 5) begin
            total++;
            if (bus.instr !== 32'h80818283) begin
               bad++; $display("FAIL rpp_word got=%h exp=80818283", bus.instr);
            end
         end
         step();
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_pc;
      logic [7:0] exp_fetch;
      logic       rdy;
      logic       rd;
      logic       redir_prev;
      logic [7:0] rpc;
      int started;
      int consumed;
      int handshakes;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      restart();
      exp_pc = 8'h00;
      exp_fetch = 8'h00;
      redir_prev = 1'b0;
      started = 0;
      consumed = 0;
      handshakes = 0;
      for (int c = 0; c < 2000; c++) begin
         if (redir_prev) begin
            total++;
            if (bus.instr_valid !== 1'b0) begin
               bad++; $display("FAIL rnd_flush cycle=%0d got=%b exp=0", c, bus.instr_valid);
            end
         end
         if (bus.imem_rd) begin
            total++;
            if (bus.imem_addr !== exp_fetch) begin
               bad++; $display("FAIL rnd_addr cycle=%0d got=%h exp=%h", c, bus.imem_addr, exp_fetch);
            end
            if (exp_fetch[1:0] == 2'b00) begin
               started++;
               total++;
               if (started - consumed > 4) begin
                  bad++; $display("FAIL rnd_overfetch cycle=%0d got=%0d exp<=4", c, started - consumed);
               end
            end
            exp_fetch++;
         end
         if (bus.instr_valid) begin
            total++;
            if (bus.instr_pc !== exp_pc || bus.instr !== word_at(exp_pc)) begin
               bad++; $display("FAIL rnd_word cycle=%0d got=%h pc=%h exp=%h pc=%h", c, bus.instr, bus.instr_pc, word_at(exp_pc), exp_pc);
            end
         end
         rdy = ($urandom_range(0, 3) != 0);
         rd  = ($urandom_range(0, 31) == 0);
         rpc = 8'($urandom_range(0, 255));
         bus.instr_ready = rdy;
         bus.redirect = rd;
         bus.redirect_pc = rpc;
         if (bus.instr_valid && rdy) begin
            exp_pc += 8'd4;
            consumed++;
            handshakes++;
         end
         if (rd) begin
            exp_pc = rpc & 8'hFC;
            exp_fetch = rpc & 8'hFC;
            started = 0;
            consumed = 0;
         end
         redir_prev = rd;
         step();
      end
      bus.redirect = 1'b0;
      total++;
      if (handshakes < 100) begin
         bad++; $display("FAIL rnd_progress got=%0d exp>=100", handshakes);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      total = 0;
      bad = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      test_reset();
      test_fill();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_async_reset();
      test_redirect_pop_push();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
